// File: rtl/seven_seg_scan_driver.sv
// Four-digit seven-segment scan driver: steps the digit index at a fixed
// refresh rate and swaps in newly loaded values only at frame boundaries.
module seven_seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [1:0]  en,
  output logic [3:0]  num,
  output logic        digit_blank,
  output logic        bcd_err,
  output logic        load_ack,
  output logic        frame_done
);

  logic [CNT_W-1:0] div;
  logic [15:0]      shadow;
  logic [15:0]      pending;
  logic             pend_v;

  logic             tc;
  logic             fb;
  logic [1:0]       idx_nxt;
  logic [15:0]      shadow_nxt;
  logic [3:0]       dig;
  logic             lz;

  // Outputs for a slot are computed from the next index and the shadow that
  // will be in force, so the first digit of a new frame shows the new value.
  always_comb begin
    tc         = (div == CNT_W'(REFRESH_DIV - 1));
    fb         = tc && (en == 2'd3);
    idx_nxt    = en + 2'd1;
    shadow_nxt = shadow;
    if (fb) begin
      if (load)
        shadow_nxt = bcd_in;
      else if (pend_v)
        shadow_nxt = pending;
    end
    dig = shadow_nxt[{idx_nxt, 2'b00} +: 4];
    case (idx_nxt)
      2'd3:    lz = (shadow_nxt[15:12] == 4'd0);
      2'd2:    lz = (shadow_nxt[15:8]  == 8'd0);
      2'd1:    lz = (shadow_nxt[15:4]  == 12'd0);
      default: lz = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div         <= '0;
      en          <= '0;
      shadow      <= '0;
      pending     <= '0;
      pend_v      <= 1'b0;
      num         <= '0;
      digit_blank <= 1'b0;
      bcd_err     <= 1'b0;
      load_ack    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      load_ack   <= 1'b0;
      frame_done <= 1'b0;
      if (tc) begin
        div         <= '0;
        en          <= idx_nxt;
        shadow      <= shadow_nxt;
        num         <= (dig > 4'd9) ? 4'd0 : dig;
        bcd_err     <= (dig > 4'd9);
        digit_blank <= blank_lz && lz;
        frame_done  <= fb;
        load_ack    <= fb && (load || pend_v);
      end else begin
        div <= div + 1'b1;
      end
      if (fb) begin
        pend_v <= 1'b0;
      end else if (load) begin
        pending <= bcd_in;
        pend_v  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver (REFRESH_DIV = 4) plus a
// REFRESH_DIV = 1 instance for the every-cycle stepping case.
module tb_seven_seg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [1:0]  en;
  logic [3:0]  num;
  logic        digit_blank;
  logic        bcd_err;
  logic        load_ack;
  logic        frame_done;

  logic [1:0]  en1;
  logic [3:0]  num1;
  logic        digit_blank1;
  logic        bcd_err1;
  logic        load_ack1;
  logic        frame_done1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  seven_seg_scan_driver #(.REFRESH_DIV(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .en(en), .num(num), .digit_blank(digit_blank), .bcd_err(bcd_err),
    .load_ack(load_ack), .frame_done(frame_done)
  );

  seven_seg_scan_driver #(.REFRESH_DIV(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
    .en(en1), .num(num1), .digit_blank(digit_blank1), .bcd_err(bcd_err1),
    .load_ack(load_ack1), .frame_done(frame_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [1:0] e, input logic [3:0] n,
                      input logic b, input logic er, input logic ak, input logic fd);
    check({tag, ".en"},    16'(en),          16'(e));
    check({tag, ".num"},   16'(num),         16'(n));
    check({tag, ".blank"}, 16'(digit_blank), 16'(b));
    check({tag, ".err"},   16'(bcd_err),     16'(er));
    check({tag, ".ack"},   16'(load_ack),    16'(ak));
    check({tag, ".fd"},    16'(frame_done),  16'(fd));
  endtask

  initial begin
    rst = 1'b1; bcd_in = '0; load = 1'b0; blank_lz = 1'b0;
    tick(2);
    slot("rst", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst1.en", 16'(en1), 16'd0);

    // 1: stepping; P0..P15 are the edges after release, tc at P3, P7, ...
    rst = 1'b0;
    tick(1); check("div1.en_a", 16'(en1), 16'd1); check("t1.en_p0", 16'(en), 16'd0);
    tick(1); check("div1.en_b", 16'(en1), 16'd2);
    tick(1); check("div1.en_c", 16'(en1), 16'd3);
    tick(1); check("div1.en_d", 16'(en1), 16'd0); check("div1.fd", 16'(frame_done1), 16'd1);
    slot("t1.p3", 2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4); check("t1.en2", 16'(en), 16'd2);
    tick(4); check("t1.en3", 16'(en), 16'd3);
    tick(3); slot("t1.p14", 2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1); slot("t1.fb", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1); check("t1.fd_low", 16'(frame_done), 16'd0);
    tick(15);  // frame start F

    // 2: mid-frame load of 1234
    tick(5); bcd_in = 16'h1234; load = 1'b1;
    tick(1); load = 1'b0;
    check("t2.old_num", 16'(num), 16'd0);
    tick(10); slot("t2.d0", 2'd0, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);  slot("t2.d1", 2'd1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);  slot("t2.d2", 2'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);  slot("t2.d3", 2'd3, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);  slot("t2.next", 2'd0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: two loads in one frame, last wins
    tick(2); bcd_in = 16'h1111; load = 1'b1;
    tick(1); load = 1'b0;
    tick(3); bcd_in = 16'h5678; load = 1'b1;
    tick(1); load = 1'b0;
    check("t3.cur_num", 16'(num), 16'd3);
    tick(9); slot("t3.d0", 2'd0, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4); slot("t3.d1", 2'd1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4); check("t3.d2", 16'(num), 16'd6);
    tick(4); check("t3.d3", 16'(num), 16'd5);
    tick(4); slot("t3.next", 2'd0, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);

    // 4: load in the fb cycle beats a pending value
    tick(3); bcd_in = 16'h1111; load = 1'b1;
    tick(1); load = 1'b0;
    check("t4.cur_num", 16'(num), 16'd7);
    tick(11); bcd_in = 16'h9999; load = 1'b1;
    tick(1); load = 1'b0;
    slot("t4.d0", 2'd0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);  slot("t4.d1", 2'd1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(12); slot("t4.next", 2'd0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);

    // 5: leading-zero blanking
    blank_lz = 1'b1; bcd_in = 16'h0045; load = 1'b1;
    tick(1); load = 1'b0;
    tick(15); slot("t5.d0", 2'd0, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);  slot("t5.d1", 2'd1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);  slot("t5.d2", 2'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(4);  slot("t5.d3", 2'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    bcd_in = 16'h0000; load = 1'b1;
    tick(1); load = 1'b0;
    tick(3); slot("t5.z0", 2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4); check("t5.z1", 16'(digit_blank), 16'd1);
    tick(4); check("t5.z2", 16'(digit_blank), 16'd1);
    tick(4); check("t5.z3", 16'(digit_blank), 16'd1);

    // 6: invalid BCD digit, then reset mid-frame drops a pending load
    blank_lz = 1'b0; bcd_in = 16'h00A3; load = 1'b1;
    tick(1); load = 1'b0;
    tick(3); slot("t6.d0", 2'd0, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4); slot("t6.d1", 2'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(4); slot("t6.d2", 2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1); bcd_in = 16'h4321; load = 1'b1;
    tick(1); load = 1'b0; rst = 1'b1;
    tick(1); slot("t6.rst", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(16); slot("t6.post", 2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
